// File: rtl/bsg_manycore_perf_pkg.sv
// Shared types for the per-tile performance counter stage: event indices,
// FSM states and the dump record layout.
`ifndef BSG_MANYCORE_PERF_REC_S
`define BSG_MANYCORE_PERF_REC_S(x_w, y_w, idx_w, cnt_w) \
  typedef struct packed { \
    logic [(x_w)-1:0]   x; \
    logic [(y_w)-1:0]   y; \
    logic [(idx_w)-1:0] idx; \
    logic [(cnt_w)-1:0] count; \
  } perf_rec_s
`endif

package bsg_manycore_perf_pkg;

  typedef enum logic [2:0] {
    CYC           = 3'd0,
    DMEM          = 3'd1,
    DX            = 3'd2,
    BT            = 3'd3,
    IN_FIFO_FULL  = 3'd4,
    OUT_FIFO_FULL = 3'd5,
    CREDIT_FULL   = 3'd6,
    RES_ACQ       = 3'd7
  } perf_event_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } perf_state_e;

  // clog2 that never returns 0, so a one-entry index still gets a bit
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_manycore_sat_counter.sv
// Saturating up-counter: sticks at all-ones, clear wins over enable.
module bsg_manycore_sat_counter #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (en_i && (count_o != {width_p{1'b1}})) begin
      count_o <= count_o + {{(width_p-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/bsg_manycore_tile_perf_counters.sv
// Per-tile performance counters: count stall events between unfreeze and
// finish, then drain one {x, y, idx, count} record per counter.
module bsg_manycore_tile_perf_counters
  import bsg_manycore_perf_pkg::*;
#(
  parameter int num_events_p    = 7,
  parameter int counter_width_p = 32,
  parameter int x_cord_width_p  = 2,
  parameter int y_cord_width_p  = 2,
  localparam int idx_width_lp   = safe_clog2(num_events_p + 1),
  localparam int rec_width_lp   = x_cord_width_p + y_cord_width_p + idx_width_lp + counter_width_p
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [x_cord_width_p-1:0] x_id_i,
  input  logic [y_cord_width_p-1:0] y_id_i,
  input  logic                      freeze_i,
  input  logic                      finish_i,
  input  logic [num_events_p-1:0]   event_i,
  output logic                      dump_v_o,
  output logic [rec_width_lp-1:0]   dump_data_o,
  input  logic                      dump_ready_i,
  output logic                      running_o,
  output logic                      done_o
);

  `BSG_MANYCORE_PERF_REC_S(x_cord_width_p, y_cord_width_p, idx_width_lp, counter_width_p);

  // Handshake: a record transfers on a cycle where dump_v_o & dump_ready_i;
  // while dump_v_o is high and ready is low, dump_data_o holds its value.

  perf_state_e                 state, state_n;
  logic                        freeze_r;
  logic [idx_width_lp-1:0]     idx;
  logic                        unfreeze, clear, count_en, accept, last_beat;
  logic [num_events_p:0]       inc;
  logic [counter_width_p-1:0]  cnt [num_events_p+1];
  perf_rec_s                   rec;

  assign unfreeze  = freeze_r & ~freeze_i;
  assign clear     = ((state == IDLE) || (state == DONE)) && unfreeze;
  assign count_en  = (state == RUN) && !freeze_i;
  assign accept    = (state == DUMP) && dump_ready_i;
  assign last_beat = (idx == idx_width_lp'(num_events_p));
  // counter 0 is the cycle count, counter k+1 tracks event k
  assign inc       = {event_i, 1'b1};

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (unfreeze) state_n = RUN;
      RUN:     if (finish_i) state_n = DUMP;
      DUMP:    if (accept && last_beat) state_n = DONE;
      DONE:    if (unfreeze) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state    <= IDLE;
      freeze_r <= 1'b1;
      idx      <= '0;
    end else begin
      state    <= state_n;
      freeze_r <= freeze_i;
      if (accept) begin
        idx <= last_beat ? '0 : idx + idx_width_lp'(1);
      end
    end
  end

  for (genvar i = 0; i <= num_events_p; i++) begin : g_cnt
    bsg_manycore_sat_counter #(.width_p(counter_width_p)) u_cnt (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clear_i   (clear),
      .en_i      (count_en & inc[i]),
      .count_o   (cnt[i])
    );
  end

  always_comb begin
    rec       = '0;
    rec.x     = x_id_i;
    rec.y     = y_id_i;
    rec.idx   = idx;
    rec.count = cnt[idx];
  end

  assign dump_data_o = rec;
  assign dump_v_o    = (state == DUMP);
  assign running_o   = (state == RUN);
  assign done_o      = (state == DONE);

endmodule

// File: tb/tb_bsg_manycore_tile_perf_counters.sv
// Bench for the per-tile perf counters: a 32-bit and a 4-bit instance share
// all stimulus; expected records come from plain per-cycle event tallies.
module tb_bsg_manycore_tile_perf_counters;

  localparam int NE   = 7;
  localparam int NREC = NE + 1;
  localparam int W    = 32;
  localparam int SW   = 4;
  localparam int RW   = 2 + 2 + 3 + W;
  localparam int SRW  = 2 + 2 + 3 + SW;
  localparam logic [1:0] X_ID = 2'b10;
  localparam logic [1:0] Y_ID = 2'b01;

  // clock / reset / inputs
  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic          freeze     = 1'b1;
  logic          finish     = 1'b0;
  logic          dump_ready = 1'b0;
  logic [1:0]    x_id       = X_ID;
  logic [1:0]    y_id       = Y_ID;
  logic [NE-1:0] ev         = '0;

  logic           dump_v, running, done;
  logic [RW-1:0]  dump_data;
  logic           s_dump_v, s_running, s_done;
  logic [SRW-1:0] s_dump_data;

  always #5 clk = ~clk;

  bsg_manycore_tile_perf_counters #(
    .num_events_p(NE), .counter_width_p(W), .x_cord_width_p(2), .y_cord_width_p(2)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .x_id_i(x_id), .y_id_i(y_id),
    .freeze_i(freeze), .finish_i(finish), .event_i(ev),
    .dump_v_o(dump_v), .dump_data_o(dump_data), .dump_ready_i(dump_ready),
    .running_o(running), .done_o(done)
  );

  bsg_manycore_tile_perf_counters #(
    .num_events_p(NE), .counter_width_p(SW), .x_cord_width_p(2), .y_cord_width_p(2)
  ) dut_small (
    .clk_i(clk), .reset_n_i(reset_n), .x_id_i(x_id), .y_id_i(y_id),
    .freeze_i(freeze), .finish_i(finish), .event_i(ev),
    .dump_v_o(s_dump_v), .dump_data_o(s_dump_data), .dump_ready_i(dump_ready),
    .running_o(s_running), .done_o(s_done)
  );

  // scoreboard
  int             pass_cnt  = 0;
  int             total_cnt = 0;
  longint         exp_cnt [NREC];
  bit             model_run = 1'b0;
  logic [RW-1:0]  exp_q   [$];
  logic [SRW-1:0] exp_s_q [$];

  function automatic logic [99:0] make_pattern(input int n, input int ones);
    logic [99:0] p;
    logic        t;
    int          j;
    p = '0;
    for (int i = 0; i < ones; i++) p[i] = 1'b1;
    for (int i = n - 1; i > 0; i--) begin
      j    = $urandom_range(i, 0);
      t    = p[i];
      p[i] = p[j];
      p[j] = t;
    end
    return p;
  endfunction

  function automatic void build_expect();
    longint         c;
    logic [2:0]     ix;
    logic [W-1:0]   cf;
    logic [SW-1:0]  cs;
    exp_q.delete();
    exp_s_q.delete();
    for (int i = 0; i < NREC; i++) begin
      c  = exp_cnt[i];
      ix = 3'(i);
      cf = (c > 64'hFFFF_FFFF) ? '1 : W'(c);
      cs = (c > 15) ? '1 : SW'(c);
      exp_q.push_back({X_ID, Y_ID, ix, cf});
      exp_s_q.push_back({X_ID, Y_ID, ix, cs});
    end
  endfunction

  // driver tasks: each is entered just after a negedge and ends on one
  task automatic run_cycle(input logic frz, input logic [NE-1:0] e, input logic fin);
    freeze = frz;
    ev     = e;
    finish = fin;
    if (model_run && !frz) begin
      exp_cnt[0]++;
      for (int k = 0; k < NE; k++) exp_cnt[k+1] += e[k];
    end
    if (model_run && fin) model_run = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({running, s_running} !== {2{model_run}})
      $display("FAIL running_flag got=%b/%b exp=%b", running, s_running, model_run);
    else pass_cnt++;
  endtask

  task automatic start_run(input logic fin);
    freeze = 1'b0;
    ev     = NE'($urandom);
    finish = fin;
    for (int i = 0; i < NREC; i++) exp_cnt[i] = 0;
    @(negedge clk);
    model_run = 1'b1;
    total_cnt++;
    if ({running, s_running, dump_v, done} !== 4'b1100)
      $display("FAIL start_run run=%b/%b v=%b done=%b exp=1/1/0/0", running, s_running, dump_v, done);
    else pass_cnt++;
  endtask

  task automatic drain(input bit toggle, input bit inject, input int abort_at);
    int beats = 0;
    int cyc   = 0;
    bit rdy;
    build_expect();
    while (beats < NREC && cyc < 100) begin
      total_cnt++;
      if (!(dump_v === 1'b1 && s_dump_v === 1'b1 &&
            dump_data === exp_q[0] && s_dump_data === exp_s_q[0]))
        $display("FAIL dump_beat beat=%0d v=%b/%b got=%h/%h exp=%h/%h",
                 beats, dump_v, s_dump_v, dump_data, s_dump_data, exp_q[0], exp_s_q[0]);
      else pass_cnt++;
      if (beats == abort_at) begin
        reset_n = 1'b0;
        return;
      end
      rdy        = toggle ? cyc[0] : 1'b1;
      dump_ready = rdy;
      if (inject) begin
        freeze = (cyc == 1);
        finish = (cyc == 2);
      end
      if (rdy) begin
        void'(exp_q.pop_front());
        void'(exp_s_q.pop_front());
        beats++;
      end
      cyc++;
      @(negedge clk);
    end
    dump_ready = 1'b0;
    finish     = 1'b0;
    total_cnt++;
    if (beats != NREC)
      $display("FAIL drain_timeout beats=%0d exp=%0d", beats, NREC);
    else if ({done, s_done, dump_v, s_dump_v, running} !== 5'b11000)
      $display("FAIL done_state done=%b/%b v=%b/%b run=%b exp=1/1/0/0/0",
               done, s_done, dump_v, s_dump_v, running);
    else pass_cnt++;
  endtask

  task automatic hold_reset(input int n);
    reset_n   = 1'b0;
    freeze    = 1'b1;
    model_run = 1'b0;
    for (int i = 0; i < n; i++) begin
      ev         = NE'($urandom);
      finish     = 1'($urandom);
      dump_ready = 1'($urandom);
      @(negedge clk);
      total_cnt++;
      if ({dump_v, running, done, s_dump_v, s_running, s_done} !== 6'b0)
        $display("FAIL reset_outputs v=%b run=%b done=%b exp=0/0/0", dump_v, running, done);
      else pass_cnt++;
    end
    reset_n    = 1'b1;
    dump_ready = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    hold_reset(3);
    freeze = 1'b1;
    finish = 1'b1;
    ev     = NE'($urandom);
    @(negedge clk);
    finish = 1'b0;
    total_cnt++;
    if ({dump_v, running, done} !== 3'b000)
      $display("FAIL idle_finish_ignored v=%b run=%b done=%b exp=0/0/0", dump_v, running, done);
    else pass_cnt++;
  endtask

  task automatic scenario2(input logic [99:0] pat, input logic fin_ev);
    start_run(1'b0);
    for (int i = 0; i < 100; i++) run_cycle(1'b0, {6'b0, pat[i]}, 1'b0);
    run_cycle(1'b0, {6'b0, fin_ev}, 1'b1);
  endtask

  task automatic test_basic();
    scenario2(make_pattern(100, 40), 1'($urandom));
    drain(1'b0, 1'b0, -1);
  endtask

  task automatic test_saturate();
    run_cycle(1'b1, '0, 1'b0);
    start_run(1'b0);
    for (int i = 0; i < 20; i++) run_cycle(1'b0, {3'b111, 4'($urandom)}, 1'b0);
    run_cycle(1'b0, 7'h7F, 1'b1);
    drain(1'b1, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_cycle(1'b1, '0, 1'b0);
    start_run(1'b0);
    for (int i = 0; i < 30; i++)
      run_cycle(($urandom_range(4, 0) == 0), NE'($urandom), 1'b0);
    run_cycle(1'b0, NE'($urandom), 1'b1);
    drain(1'b1, 1'b1, -1);
  endtask

  task automatic test_reset_abort();
    logic [99:0] pat;
    pat = make_pattern(100, 40);
    run_cycle(1'b1, '0, 1'b0);
    scenario2(pat, 1'b1);
    drain(1'b0, 1'b0, 2);
    hold_reset(2);
    run_cycle(1'b1, '0, 1'b0);
    start_run(1'b1);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, NE'($urandom), 1'b0);
    hold_reset(2);
    run_cycle(1'b1, '0, 1'b0);
    scenario2(pat, 1'b1);
    drain(1'b0, 1'b0, -1);
  endtask

  task automatic test_freeze_pause();
    logic [99:0] pat;
    pat = make_pattern(50, 10);
    run_cycle(1'b1, '0, 1'b0);
    start_run(1'b0);
    for (int i = 0; i < 50; i++) run_cycle(pat[i], NE'($urandom), 1'b0);
    run_cycle(1'b0, NE'($urandom), 1'b1);
    drain(1'b0, 1'b0, -1);
    run_cycle(1'b1, '0, 1'b0);
    start_run(1'b0);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, NE'($urandom), 1'b0);
    run_cycle(1'b1, NE'($urandom), 1'b1);
    drain(1'b1, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_back_to_back();
    test_reset_abort();
    test_freeze_pause();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim_time=%0t limit=500000", $time);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
